// File: rtl/fifo_pkg.sv
// Shared sizing helpers and storage reset value for the fifo slice.
package fifo_pkg;

  // Index width for a given entry count; pointers carry one extra wrap bit.
  function automatic int fifo_clog2(input int n);
    int r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic int ptr_bits(input int depth);
    return fifo_clog2(depth) + 1;
  endfunction

  localparam logic STORE_RST_VAL = 1'b0;

endpackage

// File: rtl/fifo_reg_we.sv
// WIDTH-bit storage row assembled from single-bit enable flops.
module reg_we
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;
    always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL)  bit_q <= STORE_RST_VAL;
      else if (we)  bit_q <= d[i];
    end
    assign q[i] = bit_q;
  end

endmodule

// File: rtl/fifo.sv
// Circular valid/ready FIFO built from enable-gated rows.
// Optional FIFO_COUNT_EN adds an occupancy output port.
module fifo
  import fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int PTR_W = fifo_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic             full,
  output logic             empty
`ifdef FIFO_COUNT_EN
  ,
  output logic [PTR_W:0]   count
`endif
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]   head_ptr, tail_ptr;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic             enq_fire, deq_fire;
  logic [DEPTH-1:0] row_we;
  logic [WIDTH-1:0] rows [DEPTH];

  assign head_idx = head_ptr[PTR_W-1:0];
  assign tail_idx = tail_ptr[PTR_W-1:0];

  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_idx == tail_idx) && (head_ptr[PTR_W] != tail_ptr[PTR_W]);

  // Ready/valid depend only on registered pointers: no bypass in either direction.
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  always_comb begin
    row_we = '0;
    if (enq_fire) row_we[tail_idx] = 1'b1;
  end

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    reg_we #(.WIDTH(WIDTH)) u_row (
      .clk    (clk),
      .rst_aL (rst_aL),
      .we     (row_we[r]),
      .d      (enq_data),
      .q      (rows[r])
    );
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (enq_fire) tail_ptr <= tail_ptr + PTR_ONE;
      if (deq_fire) head_ptr <= head_ptr + PTR_ONE;
    end
  end

  assign deq_data = rows[head_idx];

`ifdef FIFO_COUNT_EN
  assign count = tail_ptr - head_ptr;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo at DEPTH=4, WIDTH=8.
module tb_fifo;

  logic       clk;
  logic       rst_aL;
  logic       enq_valid;
  logic       enq_ready;
  logic [7:0] enq_data;
  logic       deq_valid;
  logic       deq_ready;
  logic [7:0] deq_data;
  logic       full;
  logic       empty;
`ifdef FIFO_COUNT_EN
  logic [2:0] count;
`endif

  int n_cmp;
  int n_mis;

  fifo #(.DEPTH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    enq_valid = 1'b1;
    enq_data  = d;
    deq_ready = 1'b0;
    cyc();
    enq_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_d);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    check({tag, "_vld"}, deq_valid, 1);
    check(tag, deq_data, exp_d);
    cyc();
    deq_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_aL    = 1'b1;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;

    // Asynchronous reset between edges
    #2 rst_aL = 1'b0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_enq_rdy", enq_ready, 1);
    check("rst_deq_vld", deq_valid, 0);
    check("rst_deq_data", deq_data, 8'h00);
    @(negedge clk);
    rst_aL = 1'b1;
    cyc();

    // Fill
    push(8'h11);
    check("lat_vld", deq_valid, 1);
    check("lat_data", deq_data, 8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("fill_full", full, 1);
    check("fill_enq_rdy", enq_ready, 0);
`ifdef FIFO_COUNT_EN
    check("fill_count", count, 4);
`endif
    push(8'h55);
    check("ovf_full", full, 1);
    check("ovf_head", deq_data, 8'h11);

    // Drain order
    pop_check("drain0", 8'h11);
    pop_check("drain1", 8'h22);
    pop_check("drain2", 8'h33);
    pop_check("drain3", 8'h44);
    check("drain_empty", empty, 1);
    check("drain_deq_vld", deq_valid, 0);

    // Simultaneous enqueue/dequeue at occupancy 2
    push(8'hA0);
    push(8'hA1);
    enq_valid = 1'b1;
    enq_data  = 8'hA2;
    deq_ready = 1'b1;
    check("sim_head0", deq_data, 8'hA0);
    cyc();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("sim_head1", deq_data, 8'hA1);
    check("sim_empty", empty, 0);
    check("sim_full", full, 0);
`ifdef FIFO_COUNT_EN
    check("sim_count", count, 2);
`endif
    pop_check("sim_pop1", 8'hA1);
    pop_check("sim_pop2", 8'hA2);
    check("sim_end_empty", empty, 1);

    // Wrap at occupancy 1
    push(8'h01);
    for (int i = 2; i <= 10; i++) begin
      enq_valid = 1'b1;
      enq_data  = 8'(i);
      deq_ready = 1'b1;
      check("wrap_data", deq_data, 32'(i - 1));
      cyc();
      check("wrap_full", full, 0);
      check("wrap_vld", deq_valid, 1);
    end
    enq_valid = 1'b0;
    pop_check("wrap_last", 8'h0A);
    check("wrap_empty", empty, 1);

    // Full with both handshakes: only the dequeue fires
    push(8'hB0);
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    enq_valid = 1'b1;
    enq_data  = 8'hEE;
    deq_ready = 1'b1;
    cyc();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("fb_full", full, 0);
    check("fb_head", deq_data, 8'hB1);
`ifdef FIFO_COUNT_EN
    check("fb_count", count, 3);
`endif
    pop_check("fb_pop1", 8'hB1);
    pop_check("fb_pop2", 8'hB2);
    pop_check("fb_pop3", 8'hB3);
    check("fb_empty", empty, 1);

    // Empty with both handshakes: only the enqueue fires
    enq_valid = 1'b1;
    enq_data  = 8'hC5;
    deq_ready = 1'b1;
    cyc();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("eb_vld", deq_valid, 1);
    check("eb_data", deq_data, 8'hC5);
    pop_check("eb_pop", 8'hC5);
    check("eb_empty", empty, 1);

    // Reset while full
    push(8'hD0);
    push(8'hD1);
    push(8'hD2);
    push(8'hD3);
    check("rf_full_pre", full, 1);
    #2 rst_aL = 1'b0;
    #1;
    check("rf_empty", empty, 1);
    check("rf_full", full, 0);
    check("rf_deq_data", deq_data, 8'h00);
    @(negedge clk);
    rst_aL = 1'b1;
    cyc();
    push(8'h77);
    check("rf_vld", deq_valid, 1);
    check("rf_data", deq_data, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
